// File: rtl/kernel_mem_arb_pkg.sv
// Shared types for the two-master on-chip RAM arbiter.
package kernel_mem_arb_pkg;

  localparam int unsigned ADDR_W_DEF = 15;
  localparam int unsigned DATA_W_DEF = 32;

  typedef enum logic {
    MST_0 = 1'b0,
    MST_1 = 1'b1
  } mst_e;

  typedef struct packed {
    logic valid;
    mst_e master;
  } rd_pend_t;

endpackage

// File: rtl/kernel_onchip_memory_arbiter_if.sv
// Avalon-MM master port bundle; one instance per requesting master.
interface kernel_onchip_memory_arbiter_if #(
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned BE_W   = DATA_W / 8
);
  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [BE_W-1:0]   byteenable;
  logic [DATA_W-1:0] writedata;
  logic              waitrequest;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;

  modport master (
    output address, read, write, byteenable, writedata,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, byteenable, writedata,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/kernel_mem_arb_grant.sv
// Two-way grant: round-robin pointer by default, fixed m0 priority when
// KERNEL_MEM_ARB_FIXED_PRI_EN is defined.
module kernel_mem_arb_grant
  import kernel_mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_block,
  input  logic [1:0] i_req,
  output logic       o_gnt_vld,
  output mst_e       o_gnt_mst
);

  mst_e w_pri;

`ifdef KERNEL_MEM_ARB_FIXED_PRI_EN
  assign w_pri = MST_0;
`else
  mst_e r_rr_ptr;

  // Pointer moves to the master that just lost (or did not ask) so it wins next contention.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rr_ptr <= MST_0;
    end else if (o_gnt_vld) begin
      r_rr_ptr <= (o_gnt_mst == MST_0) ? MST_1 : MST_0;
    end
  end

  assign w_pri = r_rr_ptr;
`endif

  always_comb begin
    o_gnt_vld = 1'b0;
    o_gnt_mst = MST_0;
    if (!i_block) begin
      if (&i_req) begin
        o_gnt_vld = 1'b1;
        o_gnt_mst = w_pri;
      end else if (i_req[0]) begin
        o_gnt_vld = 1'b1;
        o_gnt_mst = MST_0;
      end else if (i_req[1]) begin
        o_gnt_vld = 1'b1;
        o_gnt_mst = MST_1;
      end
    end
  end

endmodule

// File: rtl/kernel_onchip_memory_arbiter.sv
// Shares one single-port RAM between two Avalon-MM masters with per-cycle
// grant and one-cycle read response. Option: KERNEL_MEM_ARB_FIXED_PRI_EN.
module kernel_onchip_memory_arbiter
  import kernel_mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned BE_W   = DATA_W / 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   reset_req,
  kernel_onchip_memory_arbiter_if.slave m0,
  kernel_onchip_memory_arbiter_if.slave m1,
  output logic [ADDR_W-1:0]      mem_address,
  output logic [BE_W-1:0]        mem_byteenable,
  output logic                   mem_chipselect,
  output logic                   mem_write,
  output logic [DATA_W-1:0]      mem_writedata,
  output logic                   mem_clken,
  input  logic [DATA_W-1:0]      mem_readdata
);

  logic [1:0] w_req;
  logic       w_gnt_vld;
  mst_e       w_gnt_mst;
  logic       w_sel_write;
  rd_pend_t   r_rd_pend;

  assign w_req = {m1.read | m1.write, m0.read | m0.write};

  // Reset holds both masters off as well, so waitrequest reads high during reset.
  kernel_mem_arb_grant u_grant (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_block   (reset_req | ~reset_n),
    .i_req     (w_req),
    .o_gnt_vld (w_gnt_vld),
    .o_gnt_mst (w_gnt_mst)
  );

  assign m0.waitrequest = ~(w_gnt_vld && (w_gnt_mst == MST_0));
  assign m1.waitrequest = ~(w_gnt_vld && (w_gnt_mst == MST_1));

  always_comb begin
    w_sel_write    = m0.write;
    mem_address    = m0.address;
    mem_writedata  = m0.writedata;
    mem_byteenable = m0.byteenable;
    if (w_gnt_mst == MST_1) begin
      w_sel_write    = m1.write;
      mem_address    = m1.address;
      mem_writedata  = m1.writedata;
      mem_byteenable = m1.byteenable;
    end
    if (!w_sel_write) begin
      mem_byteenable = '1;
    end
  end

  assign mem_chipselect = w_gnt_vld;
  assign mem_write      = w_gnt_vld & w_sel_write;
  assign mem_clken      = reset_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_pend <= '0;
    end else begin
      r_rd_pend.valid  <= w_gnt_vld & ~w_sel_write;
      r_rd_pend.master <= w_gnt_mst;
    end
  end

  assign m0.readdatavalid = r_rd_pend.valid && (r_rd_pend.master == MST_0);
  assign m1.readdatavalid = r_rd_pend.valid && (r_rd_pend.master == MST_1);
  assign m0.readdata      = mem_readdata;
  assign m1.readdata      = mem_readdata;

endmodule
